// File: rtl/irq_event_arbiter.sv
// Event collector and arbiter for the NPU interrupt controller. It latches source edges
// as pending, arbitrates among the unmasked ones and runs a req/ack handshake.
module irq_event_arbiter #(
    parameter int NUM_SRC     = 8,
    parameter int ARB_MODE    = 0,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_event_i,
    input  logic [NUM_SRC-1:0] irq_mask_i,
    input  logic               clr_valid_i,
    input  logic [NUM_SRC-1:0] clr_mask_i,
    input  logic               clr_err_i,
    output logic               irq_req_o,
    output logic [7:0]         irq_id_o,
    input  logic               irq_ack_i,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] overrun_o,
    output logic               timeout_err_o,
    output logic               busy_o,
    output logic [1:0]         dbg_state_o
);
    // Handshake: irq_req/irq_id stay stable from the edge that enters REQ until the edge
    // that samples irq_ack=1 (or the ack timeout expires); ack outside REQ is ignored,
    // and the one-cycle GAP lets the controller drop its ack before the next request.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_GAP = 2'd2} state_e;

    localparam int CW = $clog2(ACK_TIMEOUT + 2);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic               timeout_err_q, timeout_err_d;
    logic [7:0]         irq_id_q, irq_id_d;
    logic [7:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NUM_SRC-1:0] rise, clr_vec, req_vec, rot;
    logic [7:0]         shamt, off, win_idx;
    logic [8:0]         sum;
    logic               win_found, ack_take, timeout_hit;

    assign rise        = src_event_i & ~src_q;
    assign req_vec     = pending_q & irq_mask_i;
    assign ack_take    = (state_q == ST_REQ) && irq_ack_i;
    assign timeout_hit = (state_q == ST_REQ) && !irq_ack_i && (ACK_TIMEOUT != 0)
                         && (cnt_q == CW'(ACK_TIMEOUT - 1));

    // Rotate the request vector so the search always starts at bit 0, then map back.
    always_comb begin
        shamt = 8'd0;
        if (ARB_MODE == 1) begin
            shamt = (rr_ptr_q >= 8'(NUM_SRC - 1)) ? 8'd0 : rr_ptr_q + 8'd1;
        end
        rot       = NUM_SRC'({req_vec, req_vec} >> shamt);
        win_found = 1'b0;
        off       = 8'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if ((rot & (NUM_SRC'(1) << i)) != '0) begin
                win_found = 1'b1;
                off       = 8'(i);
            end
        end
        sum     = {1'b0, shamt} + {1'b0, off};
        win_idx = (sum >= 9'(NUM_SRC)) ? 8'(sum - 9'(NUM_SRC)) : sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found) state_d = ST_REQ;
            ST_REQ:  if (ack_take || timeout_hit) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_req_o   = (state_q == ST_REQ);
        busy_o      = (state_q != ST_IDLE);
        dbg_state_o = state_q;
    end

    // A rising edge always wins over a clear of the same bit.
    always_comb begin
        clr_vec       = (clr_valid_i ? clr_mask_i : '0)
                      | (ack_take ? (NUM_SRC'(1) << irq_id_q) : '0);
        pending_d     = (pending_q & ~clr_vec) | rise;
        overrun_d     = (clr_err_i ? '0 : overrun_q) | (rise & pending_q & ~clr_vec);
        timeout_err_d = (clr_err_i ? 1'b0 : timeout_err_q) | timeout_hit;
        irq_id_d      = irq_id_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = '0;
        case (state_q)
            ST_IDLE: if (win_found) irq_id_d = win_idx;
            ST_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (ack_take) rr_ptr_d = irq_id_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q         <= '0;
            pending_q     <= '0;
            overrun_q     <= '0;
            timeout_err_q <= 1'b0;
            irq_id_q      <= 8'd0;
            rr_ptr_q      <= 8'(NUM_SRC - 1);
            cnt_q         <= '0;
        end else begin
            src_q         <= src_event_i;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            irq_id_q      <= irq_id_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign irq_id_o      = irq_id_q;
    assign pending_o     = pending_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_irq_event_arbiter.sv
// Bench for irq_event_arbiter: a fixed-priority and a round-robin instance share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_irq_event_arbiter;
    localparam int N  = 8;
    localparam int TO = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] src_event, irq_mask, clr_mask;
    logic         clr_valid, clr_err;
    logic         ack        [2];
    logic         irq_req    [2];
    logic [7:0]   irq_id     [2];
    logic [N-1:0] pending    [2];
    logic [N-1:0] overrun    [2];
    logic         timeout_err[2];
    logic         busy       [2];
    logic [1:0]   dbg_state  [2];

    irq_event_arbiter #(.NUM_SRC(N), .ARB_MODE(0), .ACK_TIMEOUT(TO)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .src_event_i(src_event), .irq_mask_i(irq_mask),
        .clr_valid_i(clr_valid), .clr_mask_i(clr_mask), .clr_err_i(clr_err),
        .irq_req_o(irq_req[0]), .irq_id_o(irq_id[0]), .irq_ack_i(ack[0]),
        .pending_o(pending[0]), .overrun_o(overrun[0]), .timeout_err_o(timeout_err[0]),
        .busy_o(busy[0]), .dbg_state_o(dbg_state[0]));

    irq_event_arbiter #(.NUM_SRC(N), .ARB_MODE(1), .ACK_TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst_n(rst_n), .src_event_i(src_event), .irq_mask_i(irq_mask),
        .clr_valid_i(clr_valid), .clr_mask_i(clr_mask), .clr_err_i(clr_err),
        .irq_req_o(irq_req[1]), .irq_id_o(irq_id[1]), .irq_ack_i(ack[1]),
        .pending_o(pending[1]), .overrun_o(overrun[1]), .timeout_err_o(timeout_err[1]),
        .busy_o(busy[1]), .dbg_state_o(dbg_state[1]));

    // reference model: phase 0 = idle, 1 = requesting, 2 = gap
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend[2];
    logic [N-1:0] m_ovr [2];
    logic         m_terr[2];
    int           m_phase[2], m_id[2], m_ptr[2], m_age[2], m_lat[2];
    logic         dut_req_prev[2];
    logic [7:0]   exp_q0[$];
    logic [7:0]   exp_q1[$];

    int n_checks = 0;
    int n_errors = 0;
    bit rnd_mode = 0;
    int fixed_lat = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_ovr[k] = '0; m_terr[k] = 1'b0;
            m_phase[k] = 0; m_id[k] = 0; m_ptr[k] = N - 1; m_age[k] = 0; m_lat[k] = 1;
            dut_req_prev[k] = 1'b0;
        end
    endtask

    function automatic int pick_lat();
        int r;
        if (!rnd_mode) return fixed_lat;
        r = $urandom_range(0, 9);
        if (r == 0) return 99;
        return r % 4;
    endfunction

    // Advance the model by one clock using the inputs applied during the cycle.
    task automatic model_step();
        logic [N-1:0] rise, clr, elig, newovr;
        bit acked, timed;
        int w;
        rise   = src_event & ~m_prev;
        m_prev = src_event;
        for (int k = 0; k < 2; k++) begin
            clr   = clr_valid ? clr_mask : '0;
            acked = (m_phase[k] == 1) && ack[k];
            timed = (m_phase[k] == 1) && !ack[k] && (m_age[k] + 1 == TO);
            if (acked) clr = clr | (N'(1) << m_id[k]);
            elig      = m_pend[k] & irq_mask;
            newovr    = rise & m_pend[k] & ~clr;
            m_pend[k] = (m_pend[k] & ~clr) | rise;
            m_ovr[k]  = (clr_err ? '0 : m_ovr[k]) | newovr;
            m_terr[k] = (clr_err ? 1'b0 : m_terr[k]) | timed;
            case (m_phase[k])
                0: if (elig != '0) begin
                    w = -1;
                    for (int j = 1; j <= N; j++) begin
                        int c;
                        c = (k == 0) ? (j - 1) : ((m_ptr[k] + j) % N);
                        if (w < 0 && ((elig >> c) & N'(1)) != '0) w = c;
                    end
                    m_id[k] = w; m_phase[k] = 1; m_age[k] = 0; m_lat[k] = pick_lat();
                    if (k == 0) exp_q0.push_back(8'(w)); else exp_q1.push_back(8'(w));
                end
                1: if (acked) begin
                    m_ptr[k] = m_id[k]; m_phase[k] = 2;
                end else if (timed) begin
                    m_phase[k] = 2;
                end else begin
                    m_age[k]++;
                end
                default: m_phase[k] = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("irq_req[%0d]", k), 32'(irq_req[k]), 32'(m_phase[k] == 1));
            check($sformatf("irq_id[%0d]", k), 32'(irq_id[k]), 32'(m_id[k]));
            check($sformatf("pending[%0d]", k), 32'(pending[k]), 32'(m_pend[k]));
            check($sformatf("overrun[%0d]", k), 32'(overrun[k]), 32'(m_ovr[k]));
            check($sformatf("timeout_err[%0d]", k), 32'(timeout_err[k]), 32'(m_terr[k]));
            check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_phase[k] != 0));
            // grant-order scoreboard
            if (irq_req[k] === 1'b1 && dut_req_prev[k] !== 1'b1) begin
                if (k == 0 && exp_q0.size() > 0) begin
                    e = exp_q0.pop_front();
                    check("grant_id[0]", 32'(irq_id[0]), 32'(e));
                end else if (k == 1 && exp_q1.size() > 0) begin
                    e = exp_q1.pop_front();
                    check("grant_id[1]", 32'(irq_id[1]), 32'(e));
                end else begin
                    check($sformatf("grant_unexpected[%0d]", k), 32'd1, 32'd0);
                end
            end
            dut_req_prev[k] = irq_req[k];
        end
    endtask

    // driver: called at a falling edge, checks, applies inputs, steps the model
    task automatic cycle(input logic [N-1:0] ev, input logic [N-1:0] mask,
                         input logic cv, input logic [N-1:0] cm, input logic ce);
        check_outputs();
        src_event = ev; irq_mask = mask; clr_valid = cv; clr_mask = cm; clr_err = ce;
        for (int k = 0; k < 2; k++) begin
            if (m_phase[k] == 1) ack[k] = (m_age[k] >= m_lat[k]);
            else                 ack[k] = rnd_mode && ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [N-1:0] mask);
        for (int i = 0; i < n; i++) cycle('0, mask, 1'b0, '0, 1'b0);
    endtask

    logic [N-1:0] ev_r, tog;

    initial begin
        src_event = '0; irq_mask = '1; clr_valid = 1'b0; clr_mask = '0; clr_err = 1'b0;
        ack[0] = 1'b0; ack[1] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // single event on source 3, ack one cycle after the request
        fixed_lat = 1;
        cycle(8'h08, '1, 1'b0, '0, 1'b0);
        idle(8, '1);

        // sources 5 and 2 together
        cycle(8'h24, '1, 1'b0, '0, 1'b0);
        idle(12, '1);

        // sources 0,1,2 re-pulsed repeatedly
        for (int r = 0; r < 6; r++) begin
            cycle(8'h07, '1, 1'b0, '0, 1'b0);
            idle(4, '1);
        end
        idle(10, '1);

        // masked source 4 collects pending and overrun, then gets unmasked
        cycle(8'h10, 8'hEF, 1'b0, '0, 1'b0);
        cycle(8'h00, 8'hEF, 1'b0, '0, 1'b0);
        cycle(8'h10, 8'hEF, 1'b0, '0, 1'b0);
        idle(4, 8'hEF);
        idle(6, '1);
        cycle(8'h00, '1, 1'b0, '0, 1'b1);
        idle(2, '1);

        // ack never arrives for source 1
        fixed_lat = 99;
        cycle(8'h02, '1, 1'b0, '0, 1'b0);
        idle(24, '1);
        fixed_lat = 1;
        idle(8, '1);
        cycle(8'h00, '1, 1'b0, '0, 1'b1);

        // clear colliding with a fresh edge on source 6
        cycle(8'h40, 8'hBF, 1'b0, '0, 1'b0);
        cycle(8'h00, 8'hBF, 1'b0, '0, 1'b0);
        cycle(8'h40, 8'hBF, 1'b1, 8'h40, 1'b0);
        cycle(8'h00, 8'hBF, 1'b1, 8'h40, 1'b0);
        idle(2, 8'hBF);

        // asynchronous reset while a request is outstanding
        fixed_lat = 99;
        cycle(8'h01, '1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10 && m_phase[0] != 1; i++) cycle('0, '1, 1'b0, '0, 1'b0);
        check("reach_req", 32'(m_phase[0] == 1), 32'd1);
        cycle('0, '1, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        fixed_lat = 1;
        idle(6, '1);

        // randomized traffic
        rnd_mode = 1;
        ev_r = src_event;
        for (int c = 0; c < 3000; c++) begin
            tog = '0;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) tog = tog | (N'(1) << b);
            ev_r = ev_r ^ tog;
            cycle(ev_r,
                  ($urandom_range(0, 3) == 0) ? N'($urandom) : '1,
                  $urandom_range(0, 15) == 0, N'($urandom),
                  $urandom_range(0, 15) == 0);
        end
        rnd_mode = 0;
        idle(TO + 8, '1);
        check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
